// File: rtl/uart_rx_module.sv
// -----------------------------------------------------------------------------
// uart_rx_module
// UART receiver: oversamples the asynchronous rx pin on the system clock and
// recovers 8-bit frames (LSB first, 1 start bit, optional parity, 1 stop bit).
// Every good byte is presented on data_out with a one-cycle valid strobe.
// Framing and parity errors are reported as one-cycle strobes.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active-high
//   en         in   receive enable, only gates the start of a new frame
//   rx         in   serial line, idle high, asynchronous to clk
//   data_out   out  [7:0] last good received byte (held until the next one)
//   valid      out  one-cycle pulse when data_out is updated
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   parity_err out  one-cycle pulse on parity mismatch (stop bit good)
//   busy       out  high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx_module #(
   parameter int CLK_FREQ = 27_000_000,
   parameter int BAUD     = 115200,
   parameter int PARITY   = 0          // 0 = none, 1 = odd, 2 = even
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int BIT_CNT = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int HALF    = BIT_CNT / 2;
   localparam int CW      = $clog2(BIT_CNT);

   localparam logic [CW-1:0] CNT_BIT_END  = CW'(BIT_CNT - 1);
   localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START      = 3'd1,
      DATA       = 3'd2,
      PARITY_BIT = 3'd3,
      STOP       = 3'd4,
      WAIT_HIGH  = 3'd5
   } state_t;

   // Expected parity bit for a received byte.
   function automatic logic parity_expected(input logic [7:0] d);
      if (PARITY == 1) begin
         return ~(^d);
      end else begin
         return ^d;
      end
   endfunction

   logic          rx_meta_r, rx_s_r, rx_d_r;
   state_t        state_r, state_n;
   logic [CW-1:0] cnt_r, cnt_n;
   logic [2:0]    idx_r, idx_n;
   logic [7:0]    shift_r, shift_n;
   logic          par_bad_r, par_bad_n;
   logic [7:0]    data_r, data_n;
   logic          valid_r, valid_n;
   logic          ferr_r, ferr_n;
   logic          perr_r, perr_n;
   logic          busy_r;

   // Two-flop synchroniser for rx plus a delayed copy for falling-edge detect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_r <= 1'b1;
         rx_s_r    <= 1'b1;
         rx_d_r    <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_s_r    <= rx_meta_r;
         rx_d_r    <= rx_s_r;
      end
   end

   // State, counters, datapath and registered output strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         idx_r     <= 3'd0;
         shift_r   <= 8'h00;
         par_bad_r <= 1'b0;
         data_r    <= 8'h00;
         valid_r   <= 1'b0;
         ferr_r    <= 1'b0;
         perr_r    <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_n;
         cnt_r     <= cnt_n;
         idx_r     <= idx_n;
         shift_r   <= shift_n;
         par_bad_r <= par_bad_n;
         data_r    <= data_n;
         valid_r   <= valid_n;
         ferr_r    <= ferr_n;
         perr_r    <= perr_n;
         busy_r    <= (state_n != IDLE);
      end
   end

   // Next-state and next-value logic for the receive FSM.
   always_comb begin
      state_n   = state_r;
      cnt_n     = cnt_r;
      idx_n     = idx_r;
      shift_n   = shift_r;
      par_bad_n = par_bad_r;
      data_n    = data_r;
      valid_n   = 1'b0;
      ferr_n    = 1'b0;
      perr_n    = 1'b0;

      case (state_r)
         IDLE: begin
            if (en && rx_d_r && !rx_s_r) begin
               state_n   = START;
               cnt_n     = '0;
               par_bad_n = 1'b0;
            end else begin
               state_n = IDLE;
            end
         end
         START: begin
            // Half a bit in: confirm the start bit; later samples land mid-bit.
            if (cnt_r == CNT_HALF_END) begin
               cnt_n = '0;
               if (rx_s_r) begin
                  state_n = IDLE;
               end else begin
                  state_n = DATA;
                  idx_n   = 3'd0;
               end
            end else begin
               cnt_n = cnt_r + CNT_ONE;
            end
         end
         DATA: begin
            if (cnt_r == CNT_BIT_END) begin
               cnt_n          = '0;
               shift_n[idx_r] = rx_s_r;
               if (idx_r == 3'd7) begin
                  state_n = (PARITY != 0) ? PARITY_BIT : STOP;
               end else begin
                  idx_n = idx_r + 3'd1;
               end
            end else begin
               cnt_n = cnt_r + CNT_ONE;
            end
         end
         PARITY_BIT: begin
            if (cnt_r == CNT_BIT_END) begin
               cnt_n     = '0;
               par_bad_n = (rx_s_r != parity_expected(shift_r));
               state_n   = STOP;
            end else begin
               cnt_n = cnt_r + CNT_ONE;
            end
         end
         STOP: begin
            // Leaving mid-stop-bit lets a back-to-back start edge be caught.
            if (cnt_r == CNT_BIT_END) begin
               cnt_n = '0;
               if (rx_s_r) begin
                  state_n = IDLE;
                  if (par_bad_r) begin
                     perr_n = 1'b1;
                  end else begin
                     data_n  = shift_r;
                     valid_n = 1'b1;
                  end
               end else begin
                  // Framing error takes priority; a held-low line is a break.
                  ferr_n  = 1'b1;
                  state_n = WAIT_HIGH;
               end
            end else begin
               cnt_n = cnt_r + CNT_ONE;
            end
         end
         WAIT_HIGH: begin
            if (rx_s_r) begin
               state_n = IDLE;
            end else begin
               state_n = WAIT_HIGH;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   assign data_out   = data_r;
   assign valid      = valid_r;
   assign frame_err  = ferr_r;
   assign parity_err = perr_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_module.sv
`timescale 1ns/1ps
module tb_uart_rx_module;

   localparam int BIT  = 234;   // (27e6 + 57600) / 115200
   localparam int HALF = 117;
   localparam int FAST = 227;   // transmitter 3% fast
   localparam int SLOW = 241;   // transmitter 3% slow

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       rx0, rx2;
   logic [7:0] d0, d2;
   logic       v0, fe0, pe0, busy0;
   logic       v2, fe2, pe2, busy2;

   int n_checks = 0;
   int n_errors = 0;

   int cyc = 0;
   int nv0 = 0, nfe0 = 0, npe0 = 0, last_v0_cyc = 0;
   int nv2 = 0, nfe2 = 0, npe2 = 0;
   logic [7:0] vdat0 [0:63];
   logic [7:0] vdat2 [0:63];

   uart_rx_module dut0 (
      .clk(clk), .rst(rst), .en(en), .rx(rx0),
      .data_out(d0), .valid(v0), .frame_err(fe0), .parity_err(pe0), .busy(busy0)
   );

   uart_rx_module #(.PARITY(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .rx(rx2),
      .data_out(d2), .valid(v2), .frame_err(fe2), .parity_err(pe2), .busy(busy2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor: counts pulses and records delivered bytes.
   always @(negedge clk) begin
      if (v0) begin
         if (nv0 < 64) vdat0[nv0] <= d0;
         nv0 <= nv0 + 1;
         last_v0_cyc <= cyc;
      end
      if (fe0) nfe0 <= nfe0 + 1;
      if (pe0) npe0 <= npe0 + 1;
      if (v2) begin
         if (nv2 < 64) vdat2[nv2] <= d2;
         nv2 <= nv2 + 1;
      end
      if (fe2) nfe2 <= nfe2 + 1;
      if (pe2) npe2 <= npe2 + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   task automatic drive_bit(input int sel, input logic val, input int period);
      if (sel == 0) rx0 = val;
      else          rx2 = val;
      repeat (period) @(negedge clk);
   endtask

   task automatic send_frame(input int sel, input logic [7:0] b, input int period,
                             input bit with_par, input logic par, input logic stop);
      drive_bit(sel, 1'b0, period);
      for (int i = 0; i < 8; i++) drive_bit(sel, b[i], period);
      if (with_par) drive_bit(sel, par, period);
      drive_bit(sel, stop, period);
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b1; rx0 = 1'b1; rx2 = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (d0 !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h expected 00", d0); end
      n_checks++; if ({v0, fe0, pe0, busy0} !== 4'b0000) begin n_errors++; $display("FAIL reset_strobes: got %b expected 0000", {v0, fe0, pe0, busy0}); end
      n_checks++; if ({d2, v2, fe2, pe2, busy2} !== 12'h000) begin n_errors++; $display("FAIL reset_dut2: got %h expected 000", {d2, v2, fe2, pe2, busy2}); end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++; if (busy0 !== 1'b0) begin n_errors++; $display("FAIL idle_busy: got %b expected 0", busy0); end
   endtask

   task automatic test_basic;
      int t0;
      logic [7:0] b;
      b = 8'h5A;
      @(negedge clk);
      n_checks++; if (busy0 !== 1'b0) begin n_errors++; $display("FAIL basic_busy_before: got %b expected 0", busy0); end
      t0 = cyc;
      drive_bit(0, 1'b0, BIT);
      n_checks++; if (busy0 !== 1'b1) begin n_errors++; $display("FAIL basic_busy_during: got %b expected 1", busy0); end
      for (int i = 0; i < 8; i++) drive_bit(0, b[i], BIT);
      drive_bit(0, 1'b1, BIT);
      repeat (2) @(negedge clk);
      n_checks++; if (nv0 !== 1) begin n_errors++; $display("FAIL basic_valid_count: got %0d expected 1", nv0); end
      n_checks++; if (d0 !== 8'h5A) begin n_errors++; $display("FAIL basic_data: got %h expected 5a", d0); end
      n_checks++; if (vdat0[0] !== 8'h5A) begin n_errors++; $display("FAIL basic_data_at_valid: got %h expected 5a", vdat0[0]); end
      n_checks++; if (last_v0_cyc - t0 !== 2 + HALF + 9 * BIT + 1) begin n_errors++; $display("FAIL basic_latency: got %0d expected %0d", last_v0_cyc - t0, 2 + HALF + 9 * BIT + 1); end
      n_checks++; if (nfe0 + npe0 !== 0) begin n_errors++; $display("FAIL basic_no_errors: got %0d expected 0", nfe0 + npe0); end
      n_checks++; if (busy0 !== 1'b0) begin n_errors++; $display("FAIL basic_busy_after: got %b expected 0", busy0); end
   endtask

   task automatic test_glitch;
      int bv, be;
      bv = nv0; be = nfe0 + npe0;
      @(negedge clk);
      rx0 = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      n_checks++; if (busy0 !== 1'b1) begin n_errors++; $display("FAIL glitch_busy_start: got %b expected 1", busy0); end
      @(negedge clk);
      rx0 = 1'b1;
      repeat (HALF + 3 - 50) @(posedge clk);
      #1;
      n_checks++; if (busy0 !== 1'b0) begin n_errors++; $display("FAIL glitch_busy_release: got %b expected 0", busy0); end
      repeat (BIT) @(negedge clk);
      n_checks++; if (nv0 !== bv) begin n_errors++; $display("FAIL glitch_no_valid: got %0d expected %0d", nv0, bv); end
      n_checks++; if (nfe0 + npe0 !== be) begin n_errors++; $display("FAIL glitch_no_error: got %0d expected %0d", nfe0 + npe0, be); end
   endtask

   task automatic test_frame_err;
      int bv, bf;
      bv = nv0; bf = nfe0;
      @(negedge clk);
      send_frame(0, 8'h3C, BIT, 1'b0, 1'b0, 1'b0);
      repeat (3 * BIT) @(negedge clk);   // line held low (break)
      n_checks++; if (nfe0 !== bf + 1) begin n_errors++; $display("FAIL ferr_count: got %0d expected %0d", nfe0, bf + 1); end
      n_checks++; if (nv0 !== bv) begin n_errors++; $display("FAIL ferr_no_valid: got %0d expected %0d", nv0, bv); end
      n_checks++; if (d0 !== 8'h5A) begin n_errors++; $display("FAIL ferr_data_held: got %h expected 5a", d0); end
      n_checks++; if (busy0 !== 1'b1) begin n_errors++; $display("FAIL ferr_wait_high: got %b expected 1", busy0); end
      rx0 = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++; if (busy0 !== 1'b0) begin n_errors++; $display("FAIL ferr_release: got %b expected 0", busy0); end
      n_checks++; if (npe0 !== 0) begin n_errors++; $display("FAIL ferr_no_perr: got %0d expected 0", npe0); end
   endtask

   task automatic test_parity;
      @(negedge clk);
      send_frame(2, 8'h01, BIT, 1'b1, 1'b0, 1'b1);
      repeat (BIT) @(negedge clk);
      n_checks++; if (npe2 !== 1) begin n_errors++; $display("FAIL parity_bad_perr: got %0d expected 1", npe2); end
      n_checks++; if (nv2 !== 0) begin n_errors++; $display("FAIL parity_bad_no_valid: got %0d expected 0", nv2); end
      n_checks++; if (d2 !== 8'h00) begin n_errors++; $display("FAIL parity_bad_data_held: got %h expected 00", d2); end
      send_frame(2, 8'h01, BIT, 1'b1, 1'b1, 1'b1);
      repeat (BIT) @(negedge clk);
      n_checks++; if (nv2 !== 1) begin n_errors++; $display("FAIL parity_good_valid: got %0d expected 1", nv2); end
      n_checks++; if (d2 !== 8'h01) begin n_errors++; $display("FAIL parity_good_data: got %h expected 01", d2); end
      n_checks++; if (npe2 !== 1 || nfe2 !== 0) begin n_errors++; $display("FAIL parity_good_errs: got perr=%0d ferr=%0d expected 1/0", npe2, nfe2); end
   endtask

   task automatic test_back_to_back(input int period);
      int bv;
      logic [7:0] exp_b [0:2];
      exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'hA5;
      bv = nv0;
      @(negedge clk);
      for (int f = 0; f < 3; f++) send_frame(0, exp_b[f], period, 1'b0, 1'b0, 1'b1);
      repeat (BIT) @(negedge clk);
      n_checks++; if (nv0 !== bv + 3) begin n_errors++; $display("FAIL b2b_%0d_count: got %0d expected %0d", period, nv0 - bv, 3); end
      for (int f = 0; f < 3; f++) begin
         n_checks++;
         if (vdat0[bv + f] !== exp_b[f]) begin n_errors++; $display("FAIL b2b_%0d_byte%0d: got %h expected %h", period, f, vdat0[bv + f], exp_b[f]); end
      end
      n_checks++; if (nfe0 !== 1 || npe0 !== 0) begin n_errors++; $display("FAIL b2b_%0d_errs: got ferr=%0d perr=%0d expected 1/0", period, nfe0, npe0); end
   endtask

   task automatic test_reset_abort;
      int bv, bf;
      logic [7:0] b;
      b = 8'h5A;
      bv = nv0; bf = nfe0 + npe0;
      @(negedge clk);
      drive_bit(0, 1'b0, BIT);
      for (int i = 0; i < 4; i++) drive_bit(0, b[i], BIT);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; rx0 = 1'b1;
      @(negedge clk);
      n_checks++; if (busy0 !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b expected 0", busy0); end
      n_checks++; if (d0 !== 8'h00) begin n_errors++; $display("FAIL abort_data_reset: got %h expected 00", d0); end
      repeat (6 * BIT) @(negedge clk);
      n_checks++; if (nv0 !== bv || nfe0 + npe0 !== bf) begin n_errors++; $display("FAIL abort_no_strobe: got valid=%0d err=%0d expected %0d/%0d", nv0, nfe0 + npe0, bv, bf); end
      send_frame(0, 8'h81, BIT, 1'b0, 1'b0, 1'b1);
      repeat (BIT) @(negedge clk);
      n_checks++; if (nv0 !== bv + 1) begin n_errors++; $display("FAIL abort_next_valid: got %0d expected %0d", nv0, bv + 1); end
      n_checks++; if (d0 !== 8'h81) begin n_errors++; $display("FAIL abort_next_data: got %h expected 81", d0); end
   endtask

   task automatic test_enable;
      int bv;
      logic [7:0] b;
      bv = nv0;
      @(negedge clk);
      en = 1'b0;
      drive_bit(0, 1'b0, BIT);
      n_checks++; if (busy0 !== 1'b0) begin n_errors++; $display("FAIL en_off_busy: got %b expected 0", busy0); end
      b = 8'h33;
      for (int i = 0; i < 8; i++) drive_bit(0, b[i], BIT);
      drive_bit(0, 1'b1, BIT);
      repeat (BIT) @(negedge clk);
      n_checks++; if (nv0 !== bv) begin n_errors++; $display("FAIL en_off_no_valid: got %0d expected %0d", nv0, bv); end
      n_checks++; if (d0 !== 8'h81) begin n_errors++; $display("FAIL en_off_data_held: got %h expected 81", d0); end
      // Enable dropped after the start: the frame still completes.
      en = 1'b1;
      b = 8'hC3;
      drive_bit(0, 1'b0, BIT);
      en = 1'b0;
      for (int i = 0; i < 8; i++) drive_bit(0, b[i], BIT);
      drive_bit(0, 1'b1, BIT);
      repeat (BIT) @(negedge clk);
      en = 1'b1;
      n_checks++; if (nv0 !== bv + 1) begin n_errors++; $display("FAIL en_mid_valid: got %0d expected %0d", nv0, bv + 1); end
      n_checks++; if (d0 !== 8'hC3) begin n_errors++; $display("FAIL en_mid_data: got %h expected c3", d0); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_parity();
      test_back_to_back(SLOW);
      test_back_to_back(FAST);
      test_reset_abort();
      test_enable();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_module.md
Name: uart_rx_module

Overview:
UART receiver, the receive-side counterpart to the existing UART_Tx_module. It lets the board accept commands from the host PC, such as a sample-rate change or a sensor select. It takes the asynchronous rx pin, oversamples it on the 27 MHz system clock, and recovers 8-bit frames (LSB first, 1 start bit, optional parity, 1 stop bit). Each good byte is presented as data_out with a one-cycle valid strobe; framing and parity errors are flagged.

Parameters:
CLK_FREQ, 27_000_000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
PARITY, 0, 0 = none, 1 = odd, 2 = even

Ports:
clk  input  1  system clock, 27 MHz
rst  input  1  asynchronous reset, active-high
en  input  1  receive enable; sampled only in IDLE
rx  input  1  serial line; idle high; asynchronous to clk
data_out  output  8  last good received byte
valid  output  1  one-cycle pulse when data_out is updated
frame_err  output  1  one-cycle pulse when the stop bit is sampled low
parity_err  output  1  one-cycle pulse on parity mismatch
busy  output  1  high while a frame is in progress (any state other than IDLE)

Behaviour:
- Derived constants:
  - BIT_CNT = (CLK_FREQ + BAUD/2) / BAUD, which is 234 at the defaults.
  - HALF = BIT_CNT / 2, which is 117.
  - Bit counter width = clog2(BIT_CNT).
- Input synchroniser: rx passes through a 2-FF synchroniser, giving rx_s. Both flops reset to 1. A third flop, rx_d, holds the previous rx_s for edge detection.
- Reset values: data_out = 8'h00, valid = 0, frame_err = 0, parity_err = 0, busy = 0, state = IDLE, all counters = 0.
- Reset mid-frame: returns to IDLE immediately, emits no strobe, and discards the partial byte.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - Falling edge (rx_d = 1, rx_s = 0) with en = 1 → START, bit counter cleared.
  - With en = 0, edges are ignored.
- START:
  - Counts to HALF-1, then samples rx_s.
  - rx_s = 1 → false start (glitch) → IDLE, no strobe.
  - rx_s = 0 → DATA, bit counter cleared, bit index = 0.
  - All later samples therefore land at mid-bit.
- DATA:
  - At count BIT_CNT-1, samples rx_s into shift[bit index] (LSB first) and clears the counter.
  - After bit index 7 → PARITY if PARITY != 0, else STOP.
- PARITY:
  - At count BIT_CNT-1, samples the parity bit.
  - Expected value: odd parity gives ^data XOR 1; even parity gives ^data.
  - The mismatch result is latched internally and goes to STOP.
- STOP, at count BIT_CNT-1:
  - rx_s = 1 and no parity mismatch → data_out <= shift and valid = 1 for exactly one cycle → IDLE.
  - rx_s = 1 with parity mismatch → parity_err pulses one cycle; data_out is unchanged and valid stays 0 → IDLE.
  - rx_s = 0 → frame_err pulses one cycle; data_out is unchanged and valid stays 0 → WAIT_HIGH. This covers a break condition.
  - If both the stop bit is low and parity mismatches, only frame_err pulses.
- WAIT_HIGH: stays until rx_s = 1, then → IDLE. No new frame can start on a held-low line.
- Latency: the strobe is registered and asserts on the cycle after the stop-bit sample. That is 2 sync cycles + HALF + 9·BIT_CNT (+BIT_CNT if parity is enabled) + 1 clk after the start-bit falling edge on rx.
- Back-to-back frames: IDLE is reached mid-stop-bit, so a start edge arriving at the nominal stop-bit end is detected with no gap needed.
- en deasserted mid-frame: the frame completes normally; en only gates new starts.
- Strobes are mutually exclusive and never asserted in consecutive cycles for the same frame.
- No internal buffering: the consumer must capture data_out on valid. data_out holds its value until the next good byte.
- Tolerance: correct reception for transmitter baud error up to ±3%.

Test Plan:
- Default params; send 0x5A (8N1) at 115200 → one valid pulse; data_out = 8'h5A; frame_err = 0 and parity_err = 0 throughout; busy high for the frame only.
- rx low pulse of 50 clk cycles, then high → no valid, no error; busy returns to 0 within HALF+3 cycles of the edge.
- Send 0x3C with the stop bit driven low → frame_err pulses once; valid = 0; data_out keeps its prior value; no new frame is accepted until rx returns high.
- PARITY = 2; send 0x01 with parity bit 0 → parity_err pulses once, no valid. Then send 0x01 with parity bit 1 → valid pulses, data_out = 8'h01.
- Back-to-back 0x00, 0xFF, 0xA5 with no idle gap, at transmitter baud +3% and then −3% → three valid pulses with data_out = 00, FF, A5 in order.
- Assert rst for 1 cycle after bit 3 of a frame, then send 0x81 → no strobe for the aborted frame; then valid with data_out = 8'h81. Also assert en = 0 during an incoming frame → no valid.
